opponent_state_decoder: RTL



---
 rtl/racer_net_pkg.sv | 44 ++++
 rtl/net_checksum16.sv | 49 ++++
 rtl/opponent_state_decoder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/racer_net_pkg.sv
// ----------------------------------------------------------------------------
// racer_net_pkg
// Shared definitions for the racer-state network link. Used by both the
// game-state transmitter and the opponent_state_decoder receiver.
//   - NET_MAGIC       : upper half of every packet header word (W0)
//   - *_LSB           : bit offsets of each field inside its packet word
//   - racer_state_t   : committed opponent state as seen by the renderers
//   - net_rx_state_t  : receiver framing FSM states
// Packet layout:
//   W0 = {magic[15:0], seq[7:0], 8'h00}
//   W1 = {x[10:0], y[10:0], stat[1:0], 8'h00}
//   W2 = {dir[8:0], 7'h0, csum[15:0]}
// ----------------------------------------------------------------------------
package racer_net_pkg;

   localparam logic [15:0] NET_MAGIC = 16'hA5C3;

   // W0 fields
   localparam int unsigned SEQ_LSB  = 8;
   // W1 fields
   localparam int unsigned X_LSB    = 21;
   localparam int unsigned Y_LSB    = 10;
   localparam int unsigned STAT_LSB = 8;
   // W2 fields
   localparam int unsigned DIR_LSB  = 23;

   // Headings are whole degrees; anything at or above this is malformed.
   localparam logic [8:0] DIR_LIMIT = 9'd360;

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic [8:0]  dir;
      logic [1:0]  stat;
   } racer_state_t;

   typedef enum logic [1:0] {
      S_HDR,
      S_POS,
      S_DIR,
      S_CHECK
   } net_rx_state_t;

endpackage

// File: rtl/net_checksum16.sv
// ----------------------------------------------------------------------------
// net_checksum16
// Running modulo-2^16 packet checksum, accumulated one word per cycle.
// Ports:
//   clk_in     : clock
//   rst_n_in   : synchronous active-low reset
//   clr        : restart the sum (combines with an add in the same cycle,
//                so the first word of a packet is summed as it arrives)
//   add_word   : add word[31:16] + word[15:0]
//   add_upper  : add word[31:16] only (add_word takes priority)
//   word       : 32-bit input word
//   sum        : current accumulated sum
// ----------------------------------------------------------------------------
module net_checksum16 (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        clr,
   input  logic        add_word,
   input  logic        add_upper,
   input  logic [31:0] word,
   output logic [15:0] sum
);

   logic [15:0] addend;
   logic [15:0] base;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      addend = 16'h0000;
      if (add_word) begin
         addend = word[31:16] + word[15:0];
      end else if (add_upper) begin
         addend = word[31:16];
      end
      base = clr ? 16'h0000 : sum;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its inputs.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         sum <= 16'h0000;
      end else if (clr || add_word || add_upper) begin
         sum <= base + addend;
      end
   end

endmodule

// File: rtl/opponent_state_decoder.sv
// ----------------------------------------------------------------------------
// opponent_state_decoder
// Frames 3-word racer-state packets from the Ethernet receiver word stream,
// validates them (checksum, heading range, optional sequence window) and
// holds the last committed opponent state for the view renderers.
// Optional feature macro: SEQ_CHECK_EN -- when defined, a packet commits only
// if its sequence number is 1..127 ahead of the last committed one.
// Parameters:
//   WORD_TIMEOUT : max idle cycles between words inside one packet
//   LINK_TIMEOUT : cycles without a commit before link_alive drops
// Ports:
//   clk_in        : eth_refclk, 50 MHz
//   rst_n_in      : synchronous active-low reset
//   axiov, axiod  : received word valid / data (no backpressure)
//   opponent_x/y  : committed position
//   opponent_dir  : committed heading, 0..359
//   opponent_stat : committed game status
//   state_valid   : a packet has been committed since reset
//   update_out    : one-cycle pulse per commit
//   link_alive    : a commit happened within the last LINK_TIMEOUT cycles
//   err_count     : saturating count of checksum/range/timeout rejects
//   stale_count   : saturating count of sequence rejects
// ----------------------------------------------------------------------------
module opponent_state_decoder
   import racer_net_pkg::*;
#(
   parameter int unsigned WORD_TIMEOUT = 64,
   parameter int unsigned LINK_TIMEOUT = 25_000_000
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        axiov,
   input  logic [31:0] axiod,
   output logic [10:0] opponent_x,
   output logic [10:0] opponent_y,
   output logic [8:0]  opponent_dir,
   output logic [1:0]  opponent_stat,
   output logic        state_valid,
   output logic        update_out,
   output logic        link_alive,
   output logic [7:0]  err_count,
   output logic [7:0]  stale_count
);

   localparam int unsigned IDLE_W = $clog2(WORD_TIMEOUT + 1);
   localparam int unsigned LINK_W = $clog2(LINK_TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(WORD_TIMEOUT - 1);
   localparam logic [LINK_W-1:0] LINK_MAX  = LINK_W'(LINK_TIMEOUT);

   net_rx_state_t     state, state_next;
   logic [IDLE_W-1:0] idle_cnt;
   logic [LINK_W-1:0] link_cnt;
   racer_state_t      opp_q;

   // Payload captured while framing
   logic [10:0] rx_x, rx_y;
   logic [1:0]  rx_stat;
   logic [8:0]  rx_dir;
   logic [15:0] rx_csum;

   // FSM strobes
   logic ld_hdr, ld_w1, ld_w2, word_timeout, do_check;
   logic [15:0] cs_sum;

   logic pkt_ok, seq_ok, commit, reject;

   net_checksum16 u_csum (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .clr       (ld_hdr),
      .add_word  (ld_hdr || ld_w1),
      .add_upper (ld_w2),
      .word      (axiod),
      .sum       (cs_sum)
   );

   // ---------------- framing FSM ----------------
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state <= S_HDR;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      ld_hdr       = 1'b0;
      ld_w1        = 1'b0;
      ld_w2        = 1'b0;
      word_timeout = 1'b0;
      do_check     = 1'b0;
      unique case (state)
         S_HDR: begin
            if (axiov && axiod[31:16] == NET_MAGIC) begin
               ld_hdr     = 1'b1;
               state_next = S_POS;
            end
         end
         S_POS: begin
            // An arriving word always beats an expiring idle count.
            if (axiov) begin
               ld_w1      = 1'b1;
               state_next = S_DIR;
            end else if (idle_cnt == IDLE_LAST) begin
               word_timeout = 1'b1;
               state_next   = S_HDR;
            end
         end
         S_DIR: begin
            if (axiov) begin
               ld_w2      = 1'b1;
               state_next = S_CHECK;
            end else if (idle_cnt == IDLE_LAST) begin
               word_timeout = 1'b1;
               state_next   = S_HDR;
            end
         end
         S_CHECK: begin
            // axiov is deliberately ignored here; a word in this cycle is lost.
            do_check   = 1'b1;
            state_next = S_HDR;
         end
         default: state_next = S_HDR;
      endcase
   end

   // ---------------- packet validation ----------------
   assign pkt_ok = (cs_sum == rx_csum) && (rx_dir < DIR_LIMIT);
   assign commit = do_check && pkt_ok && seq_ok;
   assign reject = do_check && !pkt_ok;

`ifdef SEQ_CHECK_EN
   logic [7:0] rx_seq, last_seq, seq_diff;
   logic       have_seq;

   // Forward distance modulo 256; accepted only in the "ahead" half-window.
   assign seq_diff = rx_seq - last_seq;
   assign seq_ok   = !have_seq || (seq_diff != 8'd0 && !seq_diff[7]);

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         rx_seq      <= 8'd0;
         last_seq    <= 8'd0;
         have_seq    <= 1'b0;
         stale_count <= 8'd0;
      end else begin
         if (ld_hdr) begin
            rx_seq <= axiod[SEQ_LSB +: 8];
         end
         if (commit) begin
            last_seq <= rx_seq;
            have_seq <= 1'b1;
         end
         if (do_check && pkt_ok && !seq_ok && stale_count != 8'hFF) begin
            stale_count <= stale_count + 8'd1;
         end
      end
   end
`else
   assign seq_ok      = 1'b1;
   assign stale_count = 8'd0;
`endif

   // NOTE: payload capture registers carry no reset: they are always
   // rewritten before S_CHECK reads them, so reset would only add fan-out.
   always_ff @(posedge clk_in) begin
      if (ld_w1) begin
         rx_x    <= axiod[X_LSB +: 11];
         rx_y    <= axiod[Y_LSB +: 11];
         rx_stat <= axiod[STAT_LSB +: 2];
      end
      if (ld_w2) begin
         rx_dir  <= axiod[DIR_LSB +: 9];
         rx_csum <= axiod[15:0];
      end
   end

   // ---------------- committed state, counters ----------------
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         idle_cnt    <= '0;
         opp_q       <= '0;
         state_valid <= 1'b0;
         update_out  <= 1'b0;
         link_cnt    <= LINK_MAX;
         err_count   <= 8'd0;
      end else begin
         // Counts consecutive idle cycles while mid-packet only.
         if ((state == S_POS || state == S_DIR) && !axiov && !word_timeout) begin
            idle_cnt <= idle_cnt + 1'b1;
         end else begin
            idle_cnt <= '0;
         end

         update_out <= commit;
         if (commit) begin
            opp_q       <= '{x: rx_x, y: rx_y, dir: rx_dir, stat: rx_stat};
            state_valid <= 1'b1;
            link_cnt    <= '0;
         end else if (link_cnt != LINK_MAX) begin
            link_cnt <= link_cnt + 1'b1;
         end

         if ((reject || word_timeout) && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

   assign opponent_x    = opp_q.x;
   assign opponent_y    = opp_q.y;
   assign opponent_dir  = opp_q.dir;
   assign opponent_stat = opp_q.stat;
   assign link_alive    = (link_cnt < LINK_MAX);

endmodule
